// File: rtl/vga_text_pkg.sv
// Shared geometry constants and FSM state type for the character-mode renderer.
package vga_text_pkg;

    localparam int TXT_COLS   = 70;
    localparam int TXT_ROWS   = 30;
    localparam int CELL_W     = 9;
    localparam int CELL_H     = 16;
    localparam int BUF_DEPTH  = 2100;
    localparam int BUF_AW     = 12;
    localparam logic [7:0] BLANK_CHAR = 8'h20;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

endpackage

// File: rtl/vga_text_render_buf.sv
// Character buffer: 2100x8 RAM, one synchronous read port and one write port.
// A same-cycle read and write of one address returns the previous contents.
module text_buf
    import vga_text_pkg::*;
(
    input  logic              clk,
    input  logic [BUF_AW-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              wr_en,
    input  logic [BUF_AW-1:0] wr_addr,
    input  logic [7:0]        wr_data
);

    logic [7:0] mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_text_render.sv
// Character-mode pixel generator: maps pixel coordinates to font ROM lookups
// through a 70x30 character buffer and emits FG/BG pixels two cycles later.
module vga_text_render
    import vga_text_pkg::*;
#(
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [9:0]  h_addr,
    input  logic [8:0]  v_addr,
    input  logic        wr_en,
    input  logic [6:0]  wr_x,
    input  logic [4:0]  wr_y,
    input  logic [7:0]  wr_char,
    output logic        wr_ready,
    output logic [7:0]  font_ascii,
    output logic [3:0]  font_row,
    output logic [3:0]  font_col,
    input  logic        font_bit,
    output logic        out_valid,
    output logic [23:0] vga_data
);

    state_t            state;
    logic [BUF_AW-1:0] clr_cnt;

    logic [3:0]        px_q;
    logic [6:0]        cx_q;
    logic [3:0]        px_eff;
    logic [6:0]        cx_eff;
    logic              margin;

    logic [BUF_AW-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              buf_we;
    logic [BUF_AW-1:0] buf_waddr;
    logic [7:0]        buf_wdata;
    logic              user_ok;

    logic              s1_valid;
    logic              s1_margin;
    logic [3:0]        s1_row;
    logic [3:0]        s1_col;
    logic              s1_show;

    // h_addr==0 restarts the line so counters never need an explicit line-end.
    always_comb begin
        px_eff  = (h_addr == '0) ? '0 : px_q;
        cx_eff  = (h_addr == '0) ? '0 : cx_q;
        margin  = (cx_eff >= 7'(TXT_COLS));
        rd_addr = BUF_AW'(v_addr[8:4]) * BUF_AW'(TXT_COLS) + BUF_AW'(cx_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q <= '0;
            cx_q <= '0;
        end else if (pix_valid) begin
            if (px_eff == 4'(CELL_W - 1)) begin
                px_q <= '0;
                cx_q <= margin ? cx_eff : cx_eff + 7'd1;
            end else begin
                px_q <= px_eff + 4'd1;
                cx_q <= cx_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            wr_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == BUF_AW'(BUF_DEPTH - 1)) begin
                        state    <= RUN;
                        wr_ready <= 1'b1;
                    end
                end
                RUN: begin
                    wr_ready <= 1'b1;
                end
                default: begin
                    state    <= CLEAR;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    // Clear sweep owns the write port until the FSM reaches RUN.
    always_comb begin
        user_ok = wr_en && wr_ready && (wr_x < 7'(TXT_COLS)) && (wr_y < 5'(TXT_ROWS));
        if (state == CLEAR) begin
            buf_we    = 1'b1;
            buf_waddr = clr_cnt;
            buf_wdata = BLANK_CHAR;
        end else begin
            buf_we    = user_ok;
            buf_waddr = BUF_AW'(wr_y) * BUF_AW'(TXT_COLS) + BUF_AW'(wr_x);
            buf_wdata = wr_char;
        end
    end

    text_buf u_buf (
        .clk     (clk),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (buf_we),
        .wr_addr (buf_waddr),
        .wr_data (buf_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_margin <= 1'b0;
            s1_row    <= '0;
            s1_col    <= '0;
        end else begin
            s1_valid  <= pix_valid;
            s1_margin <= margin;
            s1_row    <= v_addr[3:0];
            s1_col    <= px_eff;
        end
    end

    always_comb begin
        s1_show    = s1_valid && !s1_margin;
        font_ascii = s1_show ? rd_data : '0;
        font_row   = s1_show ? s1_row  : '0;
        font_col   = s1_show ? s1_col  : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            vga_data  <= '0;
        end else begin
            out_valid <= s1_valid;
            vga_data  <= (font_bit && s1_show && (state == RUN)) ? FG_COLOR : BG_COLOR;
        end
    end

endmodule

// File: doc/vga_text_render.md
# vga_text_render

Character-mode pixel generator between the VGA timing controller and the VGA output, acting as the reader side of the VGA font ROM. It holds a 70×30 character buffer written by the keyboard/terminal logic. It converts each incoming pixel coordinate into a (character, glyph row, glyph column) lookup on the font ROM, and emits a foreground or background RGB pixel two cycles later.

## Interface
Parameters:
- FG_COLOR, 24'hFFFFFF, RGB driven for a set glyph bit
- BG_COLOR, 24'h000000, RGB for a clear bit, blank margin, or the clear phase

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  h_addr/v_addr describe a visible pixel this cycle
- h_addr  in  10  pixel x, 0..639, increments by 1 per valid pixel within a line
- v_addr  in  9  pixel y, 0..479
- wr_en  in  1  write a character cell
- wr_x  in  7  cell column, 0..69
- wr_y  in  5  cell row, 0..29
- wr_char  in  8  ASCII code to store
- wr_ready  out  1  buffer accepts writes (RUN state)
- font_ascii  out  8  character code to the font ROM
- font_row  out  4  glyph row, 0..15
- font_col  out  4  glyph column, 0..8
- font_bit  in  1  ROM pixel bit for the current font_* address (combinational, same cycle)
- out_valid  out  1  vga_data is a valid pixel
- vga_data  out  24  RGB pixel

## Operation
- Cell geometry: 9 px wide × 16 px tall. 70 columns cover x 0..629; x 630..639 is margin and always renders BG_COLOR. Rows: cell_y = v_addr[8:4], glyph row = v_addr[3:0].
- Horizontal position uses counters (px_q 0..8, cx_q 0..69), not division:
  - When h_addr==0, the effective position is (px=0, cx=0); otherwise it is (px_q, cx_q).
  - On each valid pixel the counters advance from the effective position: px wraps 8→0 and increments cx.
  - Once cx reaches 70, the pixel is marked margin; cx saturates there until the next h_addr==0.
- Buffer: 2100×8, addressed as cell_y*70 + cell_x, with a synchronous read port and a separate write port.
  - A read and a write to the same cell in the same cycle returns the old data.
  - A write with wr_x>69 or wr_y>29 is ignored.
  - A write while wr_ready=0 is dropped.
- FSM:
  - CLEAR (entered on reset): writes 0x20 to address clr_cnt, one per cycle, counting 0..2099. The edge that writes 2099 moves the FSM to RUN.
  - RUN: user writes are accepted; the FSM stays in RUN until reset.
- During CLEAR, pixels still flow through with out_valid tracking pix_valid. vga_data is forced to BG_COLOR.
- Reset asserted mid-operation aborts the current state and restarts CLEAR at address 0.

## Timing
- Stage 0 (cycle N): pixel inputs are sampled and the buffer read address is registered.
  - Glyph row, glyph column, margin flag and valid are delayed one cycle alongside the read.
- Stage 1 (N+1):
  - font_ascii = buffer data, font_row = glyph row, font_col = glyph column. These are registered/RAM outputs, not combinational from the inputs.
  - In margin or when the stage is invalid, all font_* outputs drive 0.
- Stage 2 (N+2): out_valid = stage-1 valid, and vga_data is registered as follows:
  - FG_COLOR when font_bit=1, not margin, and state is RUN;
  - otherwise BG_COLOR.
- Latency is fixed at 2 cycles, and throughput is 1 pixel/cycle with no stalls.
- Reset values: wr_ready 0, out_valid 0, vga_data 24'h0, font_ascii/font_row/font_col 0, px_q/cx_q 0, clr_cnt 0, state CLEAR.
- wr_ready rises in the cycle after the edge that writes address 2099, which is 2100 clock edges after rst_n deasserts.
- A user write at edge E is visible to reads issued at edge E+1 or later.

## Structure
- Package vga_text_pkg holds:
  - constants TXT_COLS=70, TXT_ROWS=30, CELL_W=9, CELL_H=16, BUF_DEPTH=2100, BUF_AW=12, BLANK_CHAR=8'h20;
  - the state enum {CLEAR, RUN}.
- Sub-module text_buf: a 2100×8 RAM with one synchronous read port and one write port, no reset.
  - The write mux (clear vs. user) lives in vga_text_render.

## Test plan
- Reset release, with pix_valid continuous:
  - wr_ready stays 0 for 2100 cycles, then goes to 1.
  - vga_data is BG_COLOR throughout.
  - A read of cell (69,29) then yields font_ascii=8'h20.
- Glyph lookup, with a behavioral font ROM stub returning a known pattern:
  - Write 8'h41 to (0,0), then scan h=0..8 at v=5.
  - Two cycles after each pixel: font_ascii=8'h41, font_row=5, font_col=h.
  - vga_data equals FG_COLOR exactly where the stub bit is 1.
- Counter wrap:
  - Write 8'h42 to (1,2) and scan line v=37.
  - Pixel h=9 gives font_ascii=8'h42, font_col=0, font_row=5.
  - Pixel h=17 gives font_col=8.
- Margin:
  - With the stub bit forced to 1, pixels h=630..639 give vga_data=BG_COLOR and font_* outputs of 0.
  - h=629 gives FG_COLOR when its cell's glyph bit is 1.
- Write collisions:
  - A write to (0,0) in the same cycle as a stage-0 read of (0,0) returns the old char.
  - A write with wr_x=70 leaves the buffer unchanged.
  - A write during CLEAR is dropped.
- Mid-run reset:
  - Assert rst_n=0 while in RUN: out_valid and wr_ready drop to 0 immediately (asynchronously).
  - After release, the full 2100-cycle clear repeats and previously written cells read 8'h20.
